fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of signals between three write requesters, the arbiter and one FIFO
// write port. The arbiter uses the slave view; the requester/FIFO side uses
// the master view.
interface fifo_wr_arbiter_if #(
    parameter int DW = 8
);
    logic [2:0]    req;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] wdata2;
    logic          housefull;
    logic [2:0]    ack;
    logic [2:0]    gnt;
    logic          fifo_wr;
    logic [DW-1:0] fifo_din;
    logic          busy;

    modport slave (
        input  req, wdata0, wdata1, wdata2, housefull,
        output ack, gnt, fifo_wr, fifo_din, busy
    );

    modport master (
        output req, wdata0, wdata1, wdata2, housefull,
        input  ack, gnt, fifo_wr, fifo_din, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one of three requesters write bursts of up to
// BURST words into a shared FIFO. A grant is taken in IDLE, held through
// BURST, and always followed by one IDLE arbitration cycle.
module fifo_wr_arbiter #(
    parameter int BURST = 4,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BURST_ST} state_t;

    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    state_t     state_reg, state_next;
    logic [2:0] gnt_reg, gnt_next;
    logic [1:0] owner_reg, owner_next;
    logic [1:0] last_reg, last_next;
    logic [3:0] cnt_reg, cnt_next;

    logic [1:0]    pick;
    logic          found;
    logic          owner_req;
    logic [DW-1:0] owner_data;
    logic          wr;
    logic [2:0]    ack;
    logic [DW-1:0] din;

    // Round-robin search starting just after the last owner.
    always_comb begin
        int idx;
        pick  = 2'd0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last_reg) + k) % 3;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
    end

    // Request and data of the current owner.
    always_comb begin
        owner_req  = bus.req[owner_reg];
        owner_data = '0;
        case (owner_reg)
            2'd0:    owner_data = bus.wdata0;
            2'd1:    owner_data = bus.wdata1;
            2'd2:    owner_data = bus.wdata2;
            default: owner_data = '0;
        endcase
    end

    // Next-state logic and FIFO-side outputs.
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        wr         = 1'b0;
        ack        = 3'b000;
        din        = '0;
        case (state_reg)
            IDLE: begin
                gnt_next = 3'b000;
                if (found) begin
                    state_next = BURST_ST;
                    owner_next = pick;
                    gnt_next   = 3'(3'b001 << pick);
                    cnt_next   = 4'd0;
                end
            end
            BURST_ST: begin
                // rst gating keeps the strobe low during an aborting reset.
                wr             = owner_req & ~bus.housefull & ~rst;
                din            = owner_data;
                ack[owner_reg] = wr;
                if (!owner_req || (wr && cnt_reg == CNT_LAST)) begin
                    // A requester drop wins over burst completion: no write happens.
                    state_next = IDLE;
                    last_next  = owner_reg;
                    gnt_next   = 3'b000;
                end else if (wr) begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 3'b000;
            end
        endcase
    end

    // State and arbitration registers; last=2 after reset so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= 3'b000;
            owner_reg <= 2'd0;
            last_reg  <= 2'd2;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.fifo_wr  = wr;
    assign bus.ack      = ack;
    assign bus.fifo_din = din;
    assign bus.gnt      = gnt_reg;
    assign bus.busy     = (state_reg == BURST_ST);
endmodule
